// File: rtl/stopwatch_lap_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_lap_ctrl
//   Count-up stopwatch core, mm:ss in BCD (00:00 .. 99:59), with a lap
//   (split) capture. It takes debounced single-cycle button pulses, derives
//   its own 1 s tick from clk, and drives a 16-bit BCD word that goes
//   straight into the 4-digit FND controller.
//
// Parameters
//   TICK_DIV    clk cycles per counted second (>= 2)
//   SAT_AT_MAX  1: stop and hold at 99:59; 0: wrap to 00:00 and keep running
//
// Ports
//   clk         system clock
//   reset_p     asynchronous, active-high reset
//   start_stop  1-cycle pulse: start / pause / resume
//   lap         1-cycle pulse: freeze display at split / release split
//   clear       1-cycle pulse: zero everything (ignored while running)
//   value       {min10,min1,sec10,sec1} BCD: live count, or split while lap_hold
//   running     1 while counting
//   lap_hold    1 while the display shows the frozen split
//   max_flag    SAT_AT_MAX=1: level set on reaching 99:59;
//               SAT_AT_MAX=0: 1-cycle pulse on wrap to 00:00
// ---------------------------------------------------------------------------
module stopwatch_lap_ctrl #(
   parameter int TICK_DIV   = 100_000_000,
   parameter int SAT_AT_MAX = 1
) (
   input  logic        clk,
   input  logic        reset_p,
   input  logic        start_stop,
   input  logic        lap,
   input  logic        clear,
   output logic [15:0] value,
   output logic        running,
   output logic        lap_hold,
   output logic        max_flag
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [15:0]   MAX_CNT  = 16'h9959;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t        state, state_n;
   logic [15:0]   count, count_n;
   logic [15:0]   lap_reg, lap_n;
   logic [PW-1:0] pre, pre_n;
   logic          hold_n;
   logic          max_n;
   logic          tick;

   // One-second BCD increment; the 99:59 case is handled by the caller, so
   // every digit here stays inside its legal range.
   function automatic logic [15:0] bcd_inc(input logic [15:0] c);
      logic [3:0] m10, m1, s10, s1;
      {m10, m1, s10, s1} = c;
      if (s1 != 4'd9) begin
         s1 = s1 + 4'd1;
      end else begin
         s1 = 4'd0;
         if (s10 != 4'd5) begin
            s10 = s10 + 4'd1;
         end else begin
            s10 = 4'd0;
            if (m1 != 4'd9) begin
               m1 = m1 + 4'd1;
            end else begin
               m1  = 4'd0;
               m10 = (m10 == 4'd9) ? 4'd0 : m10 + 4'd1;
            end
         end
      end
      return {m10, m1, s10, s1};
   endfunction

   assign tick = (state == RUN) && (pre == PRE_LAST);

   always_comb begin
      state_n = state;
      count_n = count;
      lap_n   = lap_reg;
      hold_n  = lap_hold;
      pre_n   = pre;
      // In wrap mode max_flag is a pulse, so it falls back to 0 by default.
      max_n   = (SAT_AT_MAX != 0) ? max_flag : 1'b0;

      if (clear && (state != RUN)) begin
         state_n = IDLE;
         count_n = '0;
         lap_n   = '0;
         hold_n  = 1'b0;
         pre_n   = '0;
         max_n   = 1'b0;
      end else begin
         if (state == RUN)
            pre_n = tick ? '0 : pre + 1'b1;

         if (tick) begin
            if (count == MAX_CNT) begin
               max_n = 1'b1;
               if (SAT_AT_MAX != 0)
                  state_n = PAUSE;
               else
                  count_n = '0;
            end else begin
               count_n = bcd_inc(count);
            end
         end

         // start_stop outranks lap; a tick in the same cycle is still applied.
         if (start_stop) begin
            case (state)
               IDLE: begin
                  state_n = RUN;
                  pre_n   = '0;
               end
               RUN:     state_n = PAUSE;
               PAUSE:   if (!((SAT_AT_MAX != 0) && max_flag)) state_n = RUN;
               default: state_n = IDLE;
            endcase
         end else if (lap) begin
            if (lap_hold) begin
               hold_n = 1'b0;
            end else if (state == RUN) begin
               // Split takes the pre-increment count.
               lap_n  = count;
               hold_n = 1'b1;
            end
         end
      end
   end

   // Outputs are registered from the next-state values so they move on the
   // same edge that consumes the causing pulse or tick.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state    <= IDLE;
         count    <= '0;
         lap_reg  <= '0;
         pre      <= '0;
         value    <= '0;
         running  <= 1'b0;
         lap_hold <= 1'b0;
         max_flag <= 1'b0;
      end else begin
         state    <= state_n;
         count    <= count_n;
         lap_reg  <= lap_n;
         pre      <= pre_n;
         value    <= hold_n ? lap_n : count_n;
         running  <= (state_n == RUN);
         lap_hold <= hold_n;
         max_flag <= max_n;
      end
   end

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_lap_ctrl
//   Directed bench for stopwatch_lap_ctrl with TICK_DIV=4. Two instances share
//   all inputs: one saturating at 99:59, one wrapping. Expected outputs are
//   queued per instance at each step and popped against the DUT outputs,
//   sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_stopwatch_lap_ctrl;

   logic clk = 1'b0;
   logic reset_p, start_stop, lap, clear;
   logic [15:0] value_sat, value_wrap;
   logic running_sat, running_wrap, hold_sat, hold_wrap, max_sat, max_wrap;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic [15:0] val;
      logic        run;
      logic        hold;
      logic        mx;
   } exp_t;

   exp_t sb_sat[$];
   exp_t sb_wrap[$];

   always #5 clk = ~clk;

   stopwatch_lap_ctrl #(.TICK_DIV(4), .SAT_AT_MAX(1)) dut_sat (
      .clk(clk), .reset_p(reset_p), .start_stop(start_stop), .lap(lap), .clear(clear),
      .value(value_sat), .running(running_sat), .lap_hold(hold_sat), .max_flag(max_sat)
   );

   stopwatch_lap_ctrl #(.TICK_DIV(4), .SAT_AT_MAX(0)) dut_wrap (
      .clk(clk), .reset_p(reset_p), .start_stop(start_stop), .lap(lap), .clear(clear),
      .value(value_wrap), .running(running_wrap), .lap_hold(hold_wrap), .max_flag(max_wrap)
   );

   task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_now();
      exp_t e;
      while (sb_sat.size() > 0) begin
         e = sb_sat.pop_front();
         cmp({e.tag, "_sat_value"}, value_sat, e.val);
         cmp({e.tag, "_sat_running"}, {15'd0, running_sat}, {15'd0, e.run});
         cmp({e.tag, "_sat_lap_hold"}, {15'd0, hold_sat}, {15'd0, e.hold});
         cmp({e.tag, "_sat_max_flag"}, {15'd0, max_sat}, {15'd0, e.mx});
      end
      while (sb_wrap.size() > 0) begin
         e = sb_wrap.pop_front();
         cmp({e.tag, "_wrap_value"}, value_wrap, e.val);
         cmp({e.tag, "_wrap_running"}, {15'd0, running_wrap}, {15'd0, e.run});
         cmp({e.tag, "_wrap_lap_hold"}, {15'd0, hold_wrap}, {15'd0, e.hold});
         cmp({e.tag, "_wrap_max_flag"}, {15'd0, max_wrap}, {15'd0, e.mx});
      end
   endtask

   task automatic push_sat(input string tag, input logic [15:0] v, input logic r, input logic h, input logic m);
      exp_t e;
      e.tag = tag; e.val = v; e.run = r; e.hold = h; e.mx = m;
      sb_sat.push_back(e);
   endtask

   task automatic push_wrap(input string tag, input logic [15:0] v, input logic r, input logic h, input logic m);
      exp_t e;
      e.tag = tag; e.val = v; e.run = r; e.hold = h; e.mx = m;
      sb_wrap.push_back(e);
   endtask

   task automatic expect_both(input string tag, input logic [15:0] v, input logic r, input logic h, input logic m);
      push_sat(tag, v, r, h, m);
      push_wrap(tag, v, r, h, m);
      check_now();
   endtask

   // All stimulus tasks are entered and left on a falling edge.
   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start_stop = 1'b1;
      @(negedge clk);
      start_stop = 1'b0;
   endtask

   task automatic pulse_lap();
      lap = 1'b1;
      @(negedge clk);
      lap = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      reset_p    = 1'b1;
      start_stop = 1'b0;
      lap        = 1'b0;
      clear      = 1'b0;
      wait_cycles(2);
      expect_both("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      reset_p = 1'b0;
      wait_cycles(1);

      // T1: ten seconds in 40 cycles, then pause holds the value
      pulse_start();
      expect_both("t1_start", 16'h0000, 1'b1, 1'b0, 1'b0);
      wait_cycles(40);
      expect_both("t1_run40", 16'h0010, 1'b1, 1'b0, 1'b0);
      pulse_start();
      expect_both("t1_pause", 16'h0010, 1'b0, 1'b0, 1'b0);
      wait_cycles(20);
      expect_both("t1_pause_hold", 16'h0010, 1'b0, 1'b0, 1'b0);
      pulse_clear();
      expect_both("t1_clear", 16'h0000, 1'b0, 1'b0, 1'b0);

      // T2: pause with prescaler=3, resume gives a tick one cycle later
      pulse_start();
      wait_cycles(2);
      pulse_start();
      expect_both("t2_pause_frac", 16'h0000, 1'b0, 1'b0, 1'b0);
      wait_cycles(5);
      pulse_start();
      expect_both("t2_resume", 16'h0000, 1'b1, 1'b0, 1'b0);
      wait_cycles(1);
      expect_both("t2_first_tick", 16'h0001, 1'b1, 1'b0, 1'b0);
      wait_cycles(58 * 4);
      expect_both("t2_0059", 16'h0059, 1'b1, 1'b0, 1'b0);
      wait_cycles(4);
      expect_both("t2_0100", 16'h0100, 1'b1, 1'b0, 1'b0);
      pulse_start();
      expect_both("t2_pause", 16'h0100, 1'b0, 1'b0, 1'b0);
      pulse_clear();
      expect_both("t2_clear", 16'h0000, 1'b0, 1'b0, 1'b0);

      // T3/T4: run both instances to 99:59 and one tick past it
      pulse_start();
      wait_cycles(5999 * 4);
      expect_both("t34_9959", 16'h9959, 1'b1, 1'b0, 1'b0);
      wait_cycles(3);
      expect_both("t34_pre_max", 16'h9959, 1'b1, 1'b0, 1'b0);
      wait_cycles(1);
      push_sat("t3_sat", 16'h9959, 1'b0, 1'b0, 1'b1);
      push_wrap("t4_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
      check_now();
      wait_cycles(1);
      push_sat("t3_sat_level", 16'h9959, 1'b0, 1'b0, 1'b1);
      push_wrap("t4_wrap_pulse_end", 16'h0000, 1'b1, 1'b0, 1'b0);
      check_now();
      pulse_start();
      push_sat("t3_start_ignored", 16'h9959, 1'b0, 1'b0, 1'b1);
      push_wrap("t4_pause", 16'h0000, 1'b0, 1'b0, 1'b0);
      check_now();
      pulse_clear();
      expect_both("t34_clear", 16'h0000, 1'b0, 1'b0, 1'b0);

      // T5: split at 00:07, released 11 cycles later on a tick edge
      pulse_start();
      wait_cycles(28);
      expect_both("t5_0007", 16'h0007, 1'b1, 1'b0, 1'b0);
      pulse_lap();
      expect_both("t5_lap", 16'h0007, 1'b1, 1'b1, 1'b0);
      wait_cycles(10);
      expect_both("t5_frozen", 16'h0007, 1'b1, 1'b1, 1'b0);
      pulse_lap();
      expect_both("t5_release", 16'h0010, 1'b1, 1'b0, 1'b0);

      // T6: clear while running, lap in plain pause, clear+start, async reset
      pulse_clear();
      expect_both("t6_clear_ignored", 16'h0010, 1'b1, 1'b0, 1'b0);
      pulse_start();
      expect_both("t6_pause", 16'h0010, 1'b0, 1'b0, 1'b0);
      pulse_lap();
      expect_both("t6_lap_ignored", 16'h0010, 1'b0, 1'b0, 1'b0);
      clear      = 1'b1;
      start_stop = 1'b1;
      @(negedge clk);
      clear      = 1'b0;
      start_stop = 1'b0;
      expect_both("t6_clear_over_start", 16'h0000, 1'b0, 1'b0, 1'b0);
      pulse_start();
      wait_cycles(9);
      pulse_lap();
      expect_both("t6_lap2", 16'h0002, 1'b1, 1'b1, 1'b0);
      wait_cycles(3);
      expect_both("t6_lap2_held", 16'h0002, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #2 reset_p = 1'b1;
      #1;
      expect_both("t6_async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_p = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
